// File: rtl/serial_frame_sequencer.sv
// Frame controller for an async serial receiver built around an external N-bit right-shift register.
// Times bit centres, pulses the shift enable once per data bit, and hands the word over with valid/ready.
module serial_frame_sequencer #(
  parameter int N            = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx,
  output logic         sh_en,
  output logic         sh_d,
  input  logic [N-1:0] sh_q,
  output logic [N-1:0] dout,
  output logic         valid,
  input  logic         ready,
  output logic         ferr,
  output logic         overrun,
  input  logic         clr_ovr,
  output logic         busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BI_LAST   = BW'(N - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  state_t        state_nx;
  logic          rx_m;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bi;
  logic          half_hit;
  logic          bit_hit;
  logic          stop_tick;
  logic          capture;
  logic          drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  assign sh_d     = rx_s;
  assign half_hit = (cnt == HALF_LAST);
  assign bit_hit  = (cnt == BIT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (!rx_s) state_nx = START;
      START: if (half_hit) state_nx = rx_s ? IDLE : DATA;
      DATA:  if (bit_hit && (bi == BI_LAST)) state_nx = STOP;
      STOP:  if (bit_hit) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    sh_en     = 1'b0;
    stop_tick = 1'b0;
    busy      = (state != IDLE);
    case (state)
      DATA:    sh_en     = bit_hit;
      STOP:    stop_tick = bit_hit;
      default: ;
    endcase
  end

  // cnt restarts on every state change and at each data-bit boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      bi  <= '0;
    end else if ((state_nx != state) || (state == IDLE)) begin
      cnt <= '0;
      bi  <= '0;
    end else if ((state == DATA) && bit_hit) begin
      cnt <= '0;
      bi  <= bi + BW'(1);
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Handshake: a word transfers on any cycle where valid && ready; valid then
  // drops next cycle unless a new capture lands in that same cycle. dout is
  // only written on capture, so it is stable while valid is high.
  assign capture = stop_tick && rx_s && (!valid || ready);
  assign drop    = stop_tick && rx_s && valid && !ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout    <= '0;
      valid   <= 1'b0;
      ferr    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      ferr <= stop_tick && !rx_s;
      if (capture) begin
        dout  <= sh_q;
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
      if (drop)         overrun <= 1'b1;
      else if (clr_ovr) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_frame_sequencer.sv
// Directed bench for serial_frame_sequencer with a behavioural right-shift register alongside.
// Timing is checked against cycle stamps gathered by a negedge monitor.
module tb_serial_frame_sequencer;

  localparam int N   = 8;
  localparam int CPB = 16;

  logic         clk;
  logic         rst;
  logic         rx;
  logic         sh_en;
  logic         sh_d;
  logic [N-1:0] sh_q;
  logic [N-1:0] dout;
  logic         valid;
  logic         ready;
  logic         ferr;
  logic         overrun;
  logic         clr_ovr;
  logic         busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int busy_cnt = 0;
  int e0;
  int sh_times[$];
  int ferr_times[$];
  int valid_rise[$];
  logic valid_prev = 1'b0;
  logic [N-1:0] exp_q[$];

  serial_frame_sequencer #(.N(N), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rx(rx), .sh_en(sh_en), .sh_d(sh_d), .sh_q(sh_q),
    .dout(dout), .valid(valid), .ready(ready), .ferr(ferr), .overrun(overrun),
    .clr_ovr(clr_ovr), .busy(busy)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  // external shift register: right shift, serial data enters at the MSB
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        sh_q <= '0;
    else if (sh_en) sh_q <= {sh_d, sh_q[N-1:1]};
  end

  always @(negedge clk) begin
    if (sh_en) sh_times.push_back(cyc);
    if (ferr) ferr_times.push_back(cyc);
    if (busy) busy_cnt++;
    if (valid && !valid_prev) valid_rise.push_back(cyc);
    valid_prev = valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    sh_times.delete();
    ferr_times.delete();
    valid_rise.delete();
    busy_cnt = 0;
  endtask

  // drives start, data LSB-first, stop; syms < 10 cuts the frame short
  task automatic send_frame(input logic [7:0] d, input logic stp, input int syms);
    logic [9:0] f;
    f = {stp, d, 1'b0};
    for (int i = 0; i < syms; i++) begin
      rx = f[i];
      tick(CPB);
    end
    rx = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_sh_en"}, 32'(sh_en), 32'd0);
    chk({tag, "_dout"}, 32'(dout), 32'd0);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_ferr"}, 32'(ferr), 32'd0);
    chk({tag, "_overrun"}, 32'(overrun), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b0; rx = 1'b1; ready = 1'b0; clr_ovr = 1'b0;

    // asynchronous reset between clock edges
    #2 rst = 1'b1;
    #1 chk_reset_outputs("rst0");
    tick(2);
    rst = 1'b0;
    clear_mon();
    tick(100);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_no_shift", 32'(sh_times.size()), 32'd0);

    // single frame 0xA5 with ready low
    clear_mon();
    exp_q.push_back(8'hA5);
    e0 = cyc;
    send_frame(8'hA5, 1'b1, 10);
    tick(2);
    chk("a5_shift_count", 32'(sh_times.size()), 32'd8);
    if (sh_times.size() == 8)
      for (int k = 0; k < 8; k++) chk("a5_shift_time", 32'(sh_times[k]), 32'(e0 + 26 + CPB * k));
    chk("a5_valid_rises", 32'(valid_rise.size()), 32'd1);
    if (valid_rise.size() == 1) chk("a5_valid_time", 32'(valid_rise[0]), 32'(e0 + 155));
    chk("a5_dout", 32'(dout), 32'(exp_q.pop_front()));
    chk("a5_valid", 32'(valid), 32'd1);
    chk("a5_busy", 32'(busy), 32'd0);
    chk("a5_ferr_none", 32'(ferr_times.size()), 32'd0);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    chk("a5_valid_after_ready", 32'(valid), 32'd0);

    // false start: line low for 4 cycles
    clear_mon();
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(20);
    chk("fs_no_shift", 32'(sh_times.size()), 32'd0);
    chk("fs_busy_cycles", 32'(busy_cnt), 32'd8);
    chk("fs_busy_end", 32'(busy), 32'd0);
    chk("fs_valid", 32'(valid), 32'd0);

    // framing error: 0x5A with stop bit low
    clear_mon();
    e0 = cyc;
    send_frame(8'h5A, 1'b0, 10);
    tick(20);
    chk("fe_shift_count", 32'(sh_times.size()), 32'd8);
    chk("fe_ferr_pulses", 32'(ferr_times.size()), 32'd1);
    if (ferr_times.size() == 1) chk("fe_ferr_time", 32'(ferr_times[0]), 32'(e0 + 155));
    chk("fe_valid", 32'(valid), 32'd0);
    chk("fe_dout_unchanged", 32'(dout), 32'h000000A5);

    // overrun: 0x3C then 0xC3 back-to-back, never consumed
    clear_mon();
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 10);
    send_frame(8'hC3, 1'b1, 10);
    tick(2);
    chk("ov_dout", 32'(dout), 32'(exp_q.pop_front()));
    chk("ov_valid", 32'(valid), 32'd1);
    chk("ov_overrun", 32'(overrun), 32'd1);
    chk("ov_ferr_none", 32'(ferr_times.size()), 32'd0);
    clr_ovr = 1'b1;
    tick(1);
    clr_ovr = 1'b0;
    chk("ov_cleared", 32'(overrun), 32'd0);
    chk("ov_dout_held", 32'(dout), 32'h0000003C);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    chk("ov_drained", 32'(valid), 32'd0);

    // same pair, ready high only in the second stop-sample cycle
    send_frame(8'h3C, 1'b1, 10);
    exp_q.push_back(8'hC3);
    fork
      send_frame(8'hC3, 1'b1, 10);
      begin
        tick(154);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
      end
    join
    tick(2);
    chk("rc_dout", 32'(dout), 32'(exp_q.pop_front()));
    chk("rc_valid", 32'(valid), 32'd1);
    chk("rc_overrun", 32'(overrun), 32'd0);

    // reset mid-cycle while bit 3 is in flight, word C3 still held
    clear_mon();
    fork
      send_frame(8'h00, 1'b1, 5);
      begin
        tick(70);
        #2 rst = 1'b1;
        #1 chk_reset_outputs("rst_mid");
      end
    join
    tick(2);
    rst = 1'b0;
    tick(10);
    chk("rst_mid_shifts", 32'(sh_times.size()), 32'd3);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    exp_q.push_back(8'hFF);
    send_frame(8'hFF, 1'b1, 10);
    tick(3);
    chk("ff_dout", 32'(dout), 32'(exp_q.pop_front()));
    chk("ff_valid", 32'(valid), 32'd1);
    chk("ff_overrun", 32'(overrun), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
